// File: rtl/bram_window_ctrl_pkg.sv
// Shared definitions for the BRAM window controller: FSM encoding, default
// geometry and the address-width helper used by the datapath and bench.
package bram_window_ctrl_pkg;

  localparam int WR_DEPTH_DEF = 2048;
  localparam int RD_DEPTH_DEF = 512;
  localparam int PIX_W_DEF    = 8;
  localparam int DB_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STEER = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bram_addr_counter.sv
// Loadable up-counter with enable and terminal-count flag; saturates at MAX
// so a BRAM address never wraps.
module bram_addr_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 2047
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == MAX_V);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)             cnt_d = ld_val_i;
    else if (en_i && !tc_o) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bram_window_ctrl.sv
// Streams pixels into a byte-wide BRAM port, then reads it back as 32-bit
// words and steers each word out one byte lane at a time.
module bram_window_ctrl
  import bram_window_ctrl_pkg::*;
#(
  parameter int WR_DEPTH = WR_DEPTH_DEF,
  parameter int RD_DEPTH = RD_DEPTH_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  localparam int AW_A    = addr_w(WR_DEPTH),
  localparam int AW_B    = addr_w(RD_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lock_i,
  input  logic             start_i,
  input  logic             pix_valid_i,
  input  logic [PIX_W-1:0] pix_in_i,
  output logic             pix_ready_o,
  output logic             en_a_o,
  output logic             w_a_o,
  output logic [AW_A-1:0]  addra_o,
  output logic [PIX_W-1:0] dina_o,
  output logic             en_b_o,
  output logic [AW_B-1:0]  addrb_o,
  input  logic [DB_W-1:0]  db_i,
  output logic             en_steer_o,
  output logic [2:0]       select_o,
  output logic [DB_W-1:0]  register1_o,
  output logic             busy_o,
  output logic             complete_o
);

  state_e           state_q;
  logic             pix_ready_q, en_a_q, w_a_q, en_b_q, en_steer_q;
  logic             busy_q, complete_q;
  logic [AW_A-1:0]  addra_q;
  logic [PIX_W-1:0] dina_q;
  logic [2:0]       select_q;
  logic [DB_W-1:0]  register1_q;

  logic [AW_A-1:0]  wr_cnt;
  logic [AW_B-1:0]  rd_cnt;
  logic             wr_tc, rd_tc;
  logic             start_ok, accept, steer_last, lock_lost;

  assign start_ok   = (state_q == ST_IDLE) && start_i && lock_i;
  assign accept     = (state_q == ST_WRITE) && pix_ready_q && pix_valid_i && lock_i;
  assign steer_last = (state_q == ST_STEER) && (select_q == 3'd3);
  assign lock_lost  = (state_q != ST_IDLE) && !lock_i;

  bram_addr_counter #(.WIDTH(AW_A), .MAX(WR_DEPTH - 1)) u_wr_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ld_i     (start_ok),
    .ld_val_i ('0),
    .en_i     (accept),
    .cnt_o    (wr_cnt),
    .tc_o     (wr_tc)
  );

  bram_addr_counter #(.WIDTH(AW_B), .MAX(RD_DEPTH - 1)) u_rd_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ld_i     (start_ok),
    .ld_val_i ('0),
    .en_i     (steer_last && lock_i),
    .cnt_o    (rd_cnt),
    .tc_o     (rd_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      pix_ready_q <= 1'b0;
      en_a_q      <= 1'b0;
      w_a_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      en_b_q      <= 1'b0;
      en_steer_q  <= 1'b0;
      select_q    <= '0;
      register1_q <= '0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      en_a_q     <= 1'b0;
      w_a_q      <= 1'b0;
      en_b_q     <= 1'b0;
      complete_q <= 1'b0;
      // The write strobe trails its accept by one cycle, so the last write
      // lands in the first READ cycle.
      if (accept) begin
        en_a_q  <= 1'b1;
        w_a_q   <= 1'b1;
        addra_q <= wr_cnt;
        dina_q  <= pix_in_i;
      end
      if (lock_lost) begin
        state_q     <= ST_IDLE;
        pix_ready_q <= 1'b0;
        en_steer_q  <= 1'b0;
        select_q    <= '0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_ok) begin
            state_q     <= ST_WRITE;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
          ST_WRITE: if (accept && wr_tc) begin
            state_q     <= ST_READ;
            pix_ready_q <= 1'b0;
            en_b_q      <= 1'b1;
          end
          ST_READ: state_q <= ST_WAIT;
          ST_WAIT: begin
            register1_q <= db_i;
            state_q     <= ST_STEER;
            en_steer_q  <= 1'b1;
            select_q    <= '0;
          end
          ST_STEER: begin
            if (select_q == 3'd3) begin
              en_steer_q <= 1'b0;
              select_q   <= '0;
              if (rd_tc) begin
                state_q    <= ST_DONE;
                complete_q <= 1'b1;
              end else begin
                state_q <= ST_READ;
                en_b_q  <= 1'b1;
              end
            end else begin
              select_q <= select_q + 3'd1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q     <= ST_IDLE;
            pix_ready_q <= 1'b0;
            en_steer_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pix_ready_o = pix_ready_q;
  assign en_a_o      = en_a_q;
  assign w_a_o       = w_a_q;
  assign addra_o     = addra_q;
  assign dina_o      = dina_q;
  assign en_b_o      = en_b_q;
  assign addrb_o     = rd_cnt;
  assign en_steer_o  = en_steer_q;
  assign select_o    = select_q;
  assign register1_o = register1_q;
  assign busy_o      = busy_q;
  assign complete_o  = complete_q;

endmodule

// File: tb/tb_bram_window_ctrl.sv
// Scoreboard bench for bram_window_ctrl with a behavioural BRAM read port.
module tb_bram_window_ctrl;
  import bram_window_ctrl_pkg::*;

  localparam int WRD = WR_DEPTH_DEF;
  localparam int RDD = RD_DEPTH_DEF;
  localparam int PW  = PIX_W_DEF;
  localparam int AWA = $clog2(WRD);
  localparam int AWB = $clog2(RDD);

  logic          clk = 1'b0, rst_n = 1'b0, lock = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic [31:0]   db = '0;

  logic           pix_ready_o, en_a_o, w_a_o, en_b_o, en_steer_o, busy_o, complete_o;
  logic [AWA-1:0] addra_o;
  logic [PW-1:0]  dina_o;
  logic [AWB-1:0] addrb_o;
  logic [2:0]     select_o;
  logic [31:0]    register1_o;

  typedef struct packed {
    logic [AWA-1:0] addr;
    logic [PW-1:0]  data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0, failures = 0;

  bram_window_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .lock_i      (lock),
    .start_i     (start),
    .pix_valid_i (pix_valid),
    .pix_in_i    (pix_in),
    .pix_ready_o (pix_ready_o),
    .en_a_o      (en_a_o),
    .w_a_o       (w_a_o),
    .addra_o     (addra_o),
    .dina_o      (dina_o),
    .en_b_o      (en_b_o),
    .addrb_o     (addrb_o),
    .db_i        (db),
    .en_steer_o  (en_steer_o),
    .select_o    (select_o),
    .register1_o (register1_o),
    .busy_o      (busy_o),
    .complete_o  (complete_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input int a);
    logic [31:0] w;
    if (a == 5) w = 32'hA1B2C3D4;
    else        w = {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    return w;
  endfunction

  function automatic logic [PW-1:0] pix_pat(input int idx, input bit alt);
    return alt ? PW'(idx * 3 + 7) : PW'(idx);
  endfunction

  // Read port model: data appears the cycle after the enable.
  always @(posedge clk) if (en_b_o) db <= rd_word(int'(addrb_o));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b1; start = 1'b1;
    step(); step();
    checks++;
    if ({pix_ready_o, en_a_o, w_a_o, en_b_o, en_steer_o, busy_o, complete_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {pix_ready_o, en_a_o, w_a_o, en_b_o, en_steer_o, busy_o, complete_o});
    end
    checks++;
    if ({addra_o, addrb_o, dina_o, select_o, register1_o} !== '0) begin
      failures++;
      $display("FAIL reset_data addra=%0d addrb=%0d dina=%0h sel=%0d reg1=%0h exp all 0",
               addra_o, addrb_o, dina_o, select_o, register1_o);
    end
    start = 1'b0; rst_n = 1'b1;
    step();
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_release_idle busy=%b exp=0", busy_o);
    end
  endtask

  task automatic test_lock_gate();
    lock = 1'b0; start = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (busy_o !== 1'b0 || pix_ready_o !== 1'b0) begin
        failures++; $display("FAIL lock_gate busy=%b ready=%b exp 0/0", busy_o, pix_ready_o);
      end
    end
    lock = 1'b1;
    step();
    checks++;
    if (busy_o !== 1'b1 || pix_ready_o !== 1'b1) begin
      failures++; $display("FAIL lock_raise busy=%b ready=%b exp 1/1", busy_o, pix_ready_o);
    end
    start = 1'b0; lock = 1'b0;
    step();
    checks++;
    if ({busy_o, pix_ready_o, en_a_o, en_b_o, en_steer_o, complete_o} !== 6'b0) begin
      failures++;
      $display("FAIL lock_drop_write got=%b exp=0", {busy_o, pix_ready_o, en_a_o, en_b_o, en_steer_o, complete_o});
    end
    lock = 1'b1;
    step();
  endtask

  task automatic run_op(input bit alt, input bit toggle);
    int  wr_idx, rd_idx, exp_sel, cyc, t_first;
    bit  seen_done;
    wr_t e;
    wr_q.delete(); rd_q.delete();
    wr_idx = 0; rd_idx = 0; exp_sel = 0; cyc = 0; t_first = -1; seen_done = 0;
    start = 1'b1; pix_valid = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || pix_ready_o !== 1'b1) begin
      failures++; $display("FAIL start_write busy=%b ready=%b exp 1/1", busy_o, pix_ready_o);
    end
    pix_valid = 1'b1;
    pix_in = pix_pat(0, alt);
    while (!seen_done && cyc < 20000) begin
      if (pix_valid && pix_ready_o) begin
        wr_q.push_back({AWA'(wr_idx), pix_in});
        wr_idx++;
      end
      step();
      cyc++;
      if (en_a_o) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++; $display("FAIL wr_extra addra=%0d exp no write", addra_o);
        end else begin
          e = wr_q.pop_front();
          if ({w_a_o, addra_o, dina_o} !== {1'b1, e.addr, e.data}) begin
            failures++;
            $display("FAIL wr_data got w=%b addr=%0d data=%0h exp w=1 addr=%0d data=%0h",
                     w_a_o, addra_o, dina_o, e.addr, e.data);
          end
        end
      end
      if (wr_idx < WRD) begin
        checks++;
        if (pix_ready_o !== 1'b1) begin
          failures++; $display("FAIL pix_ready_held idx=%0d got=%b exp=1", wr_idx, pix_ready_o);
        end
      end
      if (en_b_o) begin
        checks++;
        if (addrb_o !== AWB'(rd_idx) || (rd_idx > 0 && exp_sel != 4)) begin
          failures++;
          $display("FAIL rd_addr got=%0d exp=%0d steer_cycles=%0d exp=4", addrb_o, rd_idx, exp_sel);
        end
        if (rd_idx == 0) t_first = cyc;
        rd_q.push_back(rd_word(rd_idx));
        rd_idx++;
        exp_sel = 0;
      end
      if (en_steer_o) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++; $display("FAIL steer_no_read sel=%0d exp no steer", select_o);
        end else if ({select_o, register1_o} !== {3'(exp_sel), rd_q[0]}) begin
          failures++;
          $display("FAIL steer got sel=%0d reg1=%0h exp sel=%0d reg1=%0h", select_o, register1_o, exp_sel, rd_q[0]);
        end
        if (addrb_o == AWB'(5)) begin
          checks++;
          if (register1_o !== 32'hA1B2C3D4) begin
            failures++; $display("FAIL reg1_addr5 got=%0h exp=a1b2c3d4", register1_o);
          end
        end
        if (exp_sel == 3 && rd_q.size() > 0) void'(rd_q.pop_front());
        exp_sel++;
      end
      if (complete_o) seen_done = 1;
      if (toggle) pix_valid = ~pix_valid;
      pix_in = pix_pat(wr_idx, alt);
    end
    pix_valid = 1'b0;
    checks++;
    if (!seen_done) begin
      failures++; $display("FAIL done_timeout complete=0 after %0d cycles exp=1", cyc);
    end
    checks++;
    if (wr_idx != WRD || wr_q.size() != 0) begin
      failures++; $display("FAIL wr_count got=%0d pending=%0d exp=%0d pending=0", wr_idx, wr_q.size(), WRD);
    end
    checks++;
    if (rd_idx != RDD) begin
      failures++; $display("FAIL rd_count got=%0d exp=%0d", rd_idx, RDD);
    end
    checks++;
    if (cyc - t_first != 6 * RDD) begin
      failures++; $display("FAIL done_latency got=%0d exp=%0d", cyc - t_first, 6 * RDD);
    end
    step();
    checks++;
    if ({busy_o, complete_o, en_a_o, en_b_o, en_steer_o} !== 5'b0) begin
      failures++;
      $display("FAIL idle_after_done got=%b exp=0", {busy_o, complete_o, en_a_o, en_b_o, en_steer_o});
    end
  endtask

  task automatic test_full();
    run_op(1'b0, 1'b0);
  endtask

  task automatic test_toggle();
    run_op(1'b1, 1'b1);
  endtask

  task automatic test_reset_midop();
    int  cyc;
    bit  found;
    cyc = 0; found = 0;
    start = 1'b1; pix_valid = 1'b1; pix_in = 8'h55;
    while (!found && cyc < 3000) begin
      step();
      cyc++;
      if (en_a_o && addra_o == AWA'(1000)) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reset_reach addra=%0d exp=1000", addra_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_ready_o, en_a_o, w_a_o, en_b_o, en_steer_o, busy_o, complete_o,
         addra_o, addrb_o, dina_o, select_o, register1_o} !== '0) begin
      failures++;
      $display("FAIL reset_async busy=%b en_a=%b addra=%0d dina=%0h exp all 0", busy_o, en_a_o, addra_o, dina_o);
    end
    pix_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({en_a_o, en_b_o} !== 2'b0 || busy_o !== 1'b1) begin
      failures++; $display("FAIL reset_release en_a=%b en_b=%b busy=%b exp 0/0/1", en_a_o, en_b_o, busy_o);
    end
    start = 1'b0; pix_valid = 1'b1; pix_in = 8'h3C;
    step();
    checks++;
    if ({en_a_o, addra_o, dina_o} !== {1'b1, AWA'(0), 8'h3C}) begin
      failures++; $display("FAIL reset_restart en_a=%b addra=%0d dina=%0h exp 1/0/3c", en_a_o, addra_o, dina_o);
    end
    lock = 1'b0; pix_valid = 1'b0;
    step();
    lock = 1'b1;
    step();
  endtask

  task automatic test_lock_drop_steer();
    int cyc;
    bit found;
    cyc = 0; found = 0;
    start = 1'b1; pix_valid = 1'b1; pix_in = 8'hA5;
    step();
    start = 1'b0;
    while (!found && cyc < 20000) begin
      step();
      cyc++;
      if (en_steer_o && addrb_o == AWB'(100) && select_o == 3'd1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL steer_reach addrb=%0d exp=100", addrb_o);
    end
    lock = 1'b0; pix_valid = 1'b0;
    step();
    checks++;
    if ({busy_o, en_steer_o, en_a_o, en_b_o, complete_o, pix_ready_o} !== 6'b0) begin
      failures++;
      $display("FAIL lock_drop_steer got=%b exp=0", {busy_o, en_steer_o, en_a_o, en_b_o, complete_o, pix_ready_o});
    end
    repeat (8) begin
      step();
      checks++;
      if (complete_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++; $display("FAIL lock_drop_quiet complete=%b busy=%b exp 0/0", complete_o, busy_o);
      end
    end
    lock = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_lock_gate();
    test_full();
    test_toggle();
    test_reset_midop();
    test_lock_drop_steer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
